// File: rtl/perst_seq.sv
// PCIe PERST# sequencer: synchronises platform reset / CPU power-good, enforces a
// minimum assertion width and releases each slot after its own staggered delay.
module perst_seq #(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 8,
    parameter int MIN_ASSERT = 8,
    parameter int REL_DLY    = 4,
    parameter int STAGGER    = 2
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iPltRstN,
    input  logic              iCpuPwrgd,
    input  logic [NUM_CH-1:0] iPerstSel,
    output logic [NUM_CH-1:0] oPerstN,
    output logic              oPltRstBufN,
    output logic              oAllReleased
);
    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MIN_ASSERT - 1);

    logic              r_plt_meta;
    logic              r_plt_sync;
    logic              r_pwr_meta;
    logic              r_pwr_sync;
    logic [NUM_CH-1:0] r_sel_meta;
    logic [NUM_CH-1:0] r_sel_sync;
    logic [NUM_CH-1:0] w_src;
    state_t            r_state [NUM_CH];
    logic [CNT_W-1:0]  r_cnt   [NUM_CH];
    logic [NUM_CH-1:0] r_perst_n;
    logic              r_all_rel;

    function automatic logic [CNT_W-1:0] f_dly(input int ch);
        return CNT_W'(REL_DLY + ch * STAGGER);
    endfunction

    function automatic logic [CNT_W-1:0] f_dly_last(input int ch);
        return CNT_W'(REL_DLY + ch * STAGGER - 1);
    endfunction

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_plt_meta <= 1'b0;
            r_plt_sync <= 1'b0;
            r_pwr_meta <= 1'b0;
            r_pwr_sync <= 1'b0;
            r_sel_meta <= '0;
            r_sel_sync <= '0;
        end else begin
            r_plt_meta <= iPltRstN;
            r_plt_sync <= r_plt_meta;
            r_pwr_meta <= iCpuPwrgd;
            r_pwr_sync <= r_pwr_meta;
            r_sel_meta <= iPerstSel;
            r_sel_sync <= r_sel_meta;
        end
    end

    assign w_src = (r_sel_sync & {NUM_CH{r_plt_sync}}) |
                   (~r_sel_sync & {NUM_CH{r_pwr_sync}});

    // In ASSERT the counter keeps running even while the source is low, so a long
    // reset pre-satisfies the minimum width and release only waits for the stagger.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_state[ch] <= ST_ASSERT;
                r_cnt[ch]   <= '0;
            end
            r_perst_n <= '0;
            r_all_rel <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_perst_n[ch] <= (r_state[ch] == ST_RUN);
                case (r_state[ch])
                    ST_ASSERT: begin
                        if (r_cnt[ch] != CNT_SAT) begin
                            r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
                        end else if (w_src[ch]) begin
                            r_cnt[ch]   <= '0;
                            r_state[ch] <= (f_dly(ch) == '0) ? ST_RUN : ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!w_src[ch]) begin
                            r_state[ch] <= ST_ASSERT;
                            r_cnt[ch]   <= '0;
                        end else if (r_cnt[ch] == f_dly_last(ch)) begin
                            r_state[ch] <= ST_RUN;
                            r_cnt[ch]   <= '0;
                        end else begin
                            r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!w_src[ch]) begin
                            r_state[ch] <= ST_ASSERT;
                            r_cnt[ch]   <= '0;
                        end
                    end
                    default: begin
                        r_state[ch] <= ST_ASSERT;
                        r_cnt[ch]   <= '0;
                    end
                endcase
            end
            r_all_rel <= &r_perst_n;
        end
    end

    assign oPerstN      = r_perst_n;
    assign oAllReleased = r_all_rel;
    assign oPltRstBufN  = iPltRstN;
endmodule

// File: tb/tb_perst_seq.sv
// Scoreboard bench for perst_seq: expected (cycle, oPerstN, oAllReleased) entries are
// queued when stimulus is driven and compared on the falling edge of that cycle.
module tb_perst_seq;
    logic       iClk = 1'b0;
    logic       iRst;
    logic       iPltRstN;
    logic       iCpuPwrgd;
    logic [2:0] iPerstSel;
    logic [2:0] oPerstN;
    logic       oPltRstBufN;
    logic       oAllReleased;

    logic clk_en = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        int         c;
        logic [2:0] p;
        logic       a;
    } exp_t;
    exp_t sb[$];

    perst_seq #(
        .NUM_CH(3), .CNT_W(8), .MIN_ASSERT(8), .REL_DLY(4), .STAGGER(2)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iPltRstN(iPltRstN),
        .iCpuPwrgd(iCpuPwrgd),
        .iPerstSel(iPerstSel),
        .oPerstN(oPerstN),
        .oPltRstBufN(oPltRstBufN),
        .oAllReleased(oAllReleased)
    );

    always #5 if (clk_en) iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    function automatic void exp_at(input int c, input logic [2:0] p, input logic a);
        exp_t e;
        e.c = c;
        e.p = p;
        e.a = a;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        iRst = 1'b1;
        iPltRstN = 1'b0;
        iCpuPwrgd = 1'b1;
        iPerstSel = 3'b111;
        repeat (3) @(negedge iClk);
        n_cmp++;
        if (oPerstN !== 3'b000 || oAllReleased !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: perst=%b all=%b, expected perst=000 all=0", oPerstN, oAllReleased);
        end
        iRst = 1'b0;
        repeat (2) @(negedge iClk);
        n_cmp++;
        if (oPerstN !== 3'b000 || oAllReleased !== 1'b0) begin
            n_err++;
            $display("FAIL reset_src_low: perst=%b all=%b, expected perst=000 all=0", oPerstN, oAllReleased);
        end
    endtask

    task automatic test_staggered_release(input string nm);
        int   e;
        int   lim;
        exp_t it;
        iPltRstN = 1'b0;
        repeat (20) @(negedge iClk);
        iPltRstN = 1'b1;
        e = cyc + 1;
        exp_at(e + 6, 3'b000, 1'b0);
        exp_at(e + 7, 3'b001, 1'b0);
        exp_at(e + 8, 3'b001, 1'b0);
        exp_at(e + 9, 3'b011, 1'b0);
        exp_at(e + 10, 3'b011, 1'b0);
        exp_at(e + 11, 3'b111, 1'b0);
        exp_at(e + 12, 3'b111, 1'b1);
        lim = cyc + 40;
        while (sb.size() > 0 && cyc < lim) begin
            @(negedge iClk);
            while (sb.size() > 0 && sb[0].c <= cyc) begin
                it = sb.pop_front();
                n_cmp++;
                if (oPerstN !== it.p || oAllReleased !== it.a || it.c != cyc) begin
                    n_err++;
                    $display("FAIL %s@E+%0d: perst=%b all=%b, expected perst=%b all=%b",
                             nm, it.c - e, oPerstN, oAllReleased, it.p, it.a);
                end
            end
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: %0d entries left, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_mixed_sources();
        int   b;
        int   e;
        int   e2;
        int   lim;
        exp_t it;
        iPerstSel = 3'b010;
        b = cyc;
        for (int k = 1; k <= 4; k++) exp_at(b + k, 3'b111, 1'b1);
        e = b + 6;
        e2 = e + 13;
        exp_at(e + 2, 3'b111, 1'b1);
        exp_at(e + 3, 3'b010, 1'b1);
        exp_at(e + 4, 3'b010, 1'b0);
        exp_at(e + 10, 3'b010, 1'b0);
        exp_at(e2 + 6, 3'b010, 1'b0);
        exp_at(e2 + 7, 3'b011, 1'b0);
        exp_at(e2 + 10, 3'b011, 1'b0);
        exp_at(e2 + 11, 3'b111, 1'b0);
        exp_at(e2 + 12, 3'b111, 1'b1);
        lim = cyc + 60;
        while (sb.size() > 0 && cyc < lim) begin
            @(negedge iClk);
            while (sb.size() > 0 && sb[0].c <= cyc) begin
                it = sb.pop_front();
                n_cmp++;
                if (oPerstN !== it.p || oAllReleased !== it.a || it.c != cyc) begin
                    n_err++;
                    $display("FAIL mixed@%0d: perst=%b all=%b, expected perst=%b all=%b",
                             it.c - b, oPerstN, oAllReleased, it.p, it.a);
                end
            end
            if (cyc == e - 1) iCpuPwrgd = 1'b0;
            if (cyc == e2 - 1) iCpuPwrgd = 1'b1;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mixed_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
        iPerstSel = 3'b111;
        repeat (4) @(negedge iClk);
    endtask

    task automatic test_short_pulse();
        int   e;
        int   lim;
        exp_t it;
        iPltRstN = 1'b0;
        e = cyc + 1;
        @(negedge iClk);
        iPltRstN = 1'b1;
        exp_at(e + 2, 3'b111, 1'b1);
        exp_at(e + 3, 3'b000, 1'b1);
        exp_at(e + 4, 3'b000, 1'b0);
        exp_at(e + 14, 3'b000, 1'b0);
        exp_at(e + 15, 3'b001, 1'b0);
        exp_at(e + 16, 3'b001, 1'b0);
        exp_at(e + 17, 3'b011, 1'b0);
        exp_at(e + 18, 3'b011, 1'b0);
        exp_at(e + 19, 3'b111, 1'b0);
        exp_at(e + 20, 3'b111, 1'b1);
        lim = cyc + 40;
        while (sb.size() > 0 && cyc < lim) begin
            @(negedge iClk);
            while (sb.size() > 0 && sb[0].c <= cyc) begin
                it = sb.pop_front();
                n_cmp++;
                if (oPerstN !== it.p || oAllReleased !== it.a || it.c != cyc) begin
                    n_err++;
                    $display("FAIL short_pulse@E+%0d: perst=%b all=%b, expected perst=%b all=%b",
                             it.c - e, oPerstN, oAllReleased, it.p, it.a);
                end
            end
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL short_pulse_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_drop_in_hold();
        int   e;
        int   r;
        int   lim;
        exp_t it;
        iPltRstN = 1'b0;
        repeat (20) @(negedge iClk);
        iPltRstN = 1'b1;
        e = cyc + 1;
        r = e + 6;
        exp_at(e + 7, 3'b000, 1'b0);
        exp_at(r + 12, 3'b000, 1'b0);
        exp_at(r + 13, 3'b001, 1'b0);
        exp_at(r + 14, 3'b001, 1'b0);
        exp_at(r + 15, 3'b011, 1'b0);
        exp_at(r + 16, 3'b011, 1'b0);
        exp_at(r + 17, 3'b111, 1'b0);
        exp_at(r + 18, 3'b111, 1'b1);
        lim = cyc + 50;
        while (sb.size() > 0 && cyc < lim) begin
            @(negedge iClk);
            while (sb.size() > 0 && sb[0].c <= cyc) begin
                it = sb.pop_front();
                n_cmp++;
                if (oPerstN !== it.p || oAllReleased !== it.a || it.c != cyc) begin
                    n_err++;
                    $display("FAIL drop_in_hold@E+%0d: perst=%b all=%b, expected perst=%b all=%b",
                             it.c - e, oPerstN, oAllReleased, it.p, it.a);
                end
            end
            if (cyc == e + 3) iPltRstN = 1'b0;
            if (cyc == e + 4) iPltRstN = 1'b1;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drop_in_hold_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_buffer_path();
        logic v;
        @(negedge iClk);
        clk_en = 1'b0;
        #3;
        for (int k = 0; k < 4; k++) begin
            v = k[0];
            iPltRstN = v;
            #1;
            n_cmp++;
            if (oPltRstBufN !== v) begin
                n_err++;
                $display("FAIL buffer_follow_%0d: buf=%b, expected %b", k, oPltRstBufN, v);
            end
            n_cmp++;
            if (oPerstN !== 3'b111 || oAllReleased !== 1'b1) begin
                n_err++;
                $display("FAIL buffer_no_clk_%0d: perst=%b all=%b, expected perst=111 all=1", k, oPerstN, oAllReleased);
            end
        end
        iPltRstN = 1'b1;
        #1;
        clk_en = 1'b1;
        repeat (4) @(negedge iClk);
        n_cmp++;
        if (oPerstN !== 3'b111 || oAllReleased !== 1'b1) begin
            n_err++;
            $display("FAIL buffer_restart: perst=%b all=%b, expected perst=111 all=1", oPerstN, oAllReleased);
        end
    endtask

    task automatic test_async_reset();
        @(negedge iClk);
        n_cmp++;
        if (oPerstN !== 3'b111 || oAllReleased !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre: perst=%b all=%b, expected perst=111 all=1", oPerstN, oAllReleased);
        end
        #2;
        iRst = 1'b1;
        iPltRstN = 1'b0;
        #1;
        n_cmp++;
        if (oPerstN !== 3'b000 || oAllReleased !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: perst=%b all=%b, expected perst=000 all=0", oPerstN, oAllReleased);
        end
        #1;
        iRst = 1'b0;
        test_staggered_release("async_rerelease");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_staggered_release("staggered");
        test_mixed_sources();
        test_short_pulse();
        test_drop_in_hold();
        test_buffer_path();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
